// File: rtl/router_reg.sv
// router_reg: datapath register stage of the 1x3 router.
// Latches the header and steers header, payload and parity bytes onto dout
// under the FSM state strobes. A byte that arrives while the FIFO is full is
// held and replayed later. Running XOR parity is checked against the
// packet's parity byte.
module router_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             pkt_valid,
    input  logic [WIDTH-1:0] data_in,
    input  logic             fifo_full,
    input  logic             detect_add,
    input  logic             lfd_state,
    input  logic             ld_state,
    input  logic             laf_state,
    input  logic             full_state,
    input  logic             rst_int_reg,
    output logic [WIDTH-1:0] dout,
    output logic             parity_done,
    output logic             low_pkt_valid,
    output logic             err
);

    logic [WIDTH-1:0] header_byte;
    logic [WIDTH-1:0] full_byte;
    logic [WIDTH-1:0] internal_parity;
    logic [WIDTH-1:0] packet_parity;

    // Capture the header byte; an invalid address (2'b11) leaves the old header in place.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            header_byte <= '0;
        end else if (detect_add && pkt_valid && (data_in[1:0] != 2'b11)) begin
            header_byte <= data_in;
        end
    end

    // Output byte steering; a byte seen while the FIFO is full parks in full_byte.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            dout      <= '0;
            full_byte <= '0;
        end else if (lfd_state) begin
            dout <= header_byte;
        end else if (ld_state && !fifo_full) begin
            dout <= data_in;
        end else if (ld_state && fifo_full) begin
            full_byte <= data_in;
        end else if (laf_state) begin
            dout <= full_byte;
        end
    end

    // Running parity over header and payload; the parity byte itself is excluded.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            internal_parity <= '0;
        end else if (detect_add) begin
            internal_parity <= '0;
        end else if (lfd_state) begin
            internal_parity <= internal_parity ^ header_byte;
        end else if (ld_state && pkt_valid && !full_state) begin
            internal_parity <= internal_parity ^ data_in;
        end
    end

    // Capture the received parity byte (the byte presented with pkt_valid low).
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            packet_parity <= '0;
        end else if (ld_state && !pkt_valid) begin
            packet_parity <= data_in;
        end else if (detect_add) begin
            packet_parity <= '0;
        end
    end

    // Flag that pkt_valid fell while loading; cleared only by the FSM's rst_int_reg.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            low_pkt_valid <= 1'b0;
        end else if (rst_int_reg) begin
            low_pkt_valid <= 1'b0;
        end else if (ld_state && !pkt_valid) begin
            low_pkt_valid <= 1'b1;
        end
    end

    // Parity byte written, either directly or replayed from full_byte.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            parity_done <= 1'b0;
        end else if (detect_add) begin
            parity_done <= 1'b0;
        end else if ((ld_state && !fifo_full && !pkt_valid) ||
                     (laf_state && low_pkt_valid && !parity_done)) begin
            parity_done <= 1'b1;
        end
    end

    // Parity compare, evaluated once both parity registers are final.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            err <= 1'b0;
        end else if (detect_add) begin
            err <= 1'b0;
        end else if (parity_done) begin
            err <= (internal_parity != packet_parity);
        end
    end

endmodule

// File: tb/tb_router_reg.sv
// tb_router_reg: self-checking bench for router_reg. The bench plays the FSM,
// and a packet-level model predicts the byte stream, parity result and flags.
module tb_router_reg;

    logic       clock;
    logic       resetn;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic       fifo_full;
    logic       detect_add;
    logic       lfd_state;
    logic       ld_state;
    logic       laf_state;
    logic       full_state;
    logic       rst_int_reg;
    logic [7:0] dout;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       err;

    int errors = 0;
    int checks = 0;

    // Model state: last header the DUT should have accepted.
    logic [7:0] model_hdr;
    logic [7:0] pl_q[$];

    router_reg #(.WIDTH(8)) dut (
        .clock        (clock),
        .resetn       (resetn),
        .pkt_valid    (pkt_valid),
        .data_in      (data_in),
        .fifo_full    (fifo_full),
        .detect_add   (detect_add),
        .lfd_state    (lfd_state),
        .ld_state     (ld_state),
        .laf_state    (laf_state),
        .full_state   (full_state),
        .rst_int_reg  (rst_int_reg),
        .dout         (dout),
        .parity_done  (parity_done),
        .low_pkt_valid(low_pkt_valid),
        .err          (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_strobes();
        detect_add  = 1'b0;
        lfd_state   = 1'b0;
        ld_state    = 1'b0;
        laf_state   = 1'b0;
        full_state  = 1'b0;
        rst_int_reg = 1'b0;
        fifo_full   = 1'b0;
    endtask

    // Drive one packet of pl_q payload bytes. full_idx selects which byte
    // (payload index, or pl_q.size() for the parity byte) hits a full FIFO;
    // rnd_full instead picks full bytes at random.
    task automatic send_packet(input logic [7:0] hdr, input logic [7:0] par,
                               input int full_idx, input bit rnd_full);
        logic [7:0] exp_par;
        logic [7:0] last;
        logic [7:0] b;
        bit         full;
        bit         is_par;
        int         n;
        clear_strobes();
        detect_add = 1'b1;
        pkt_valid  = 1'b1;
        data_in    = hdr;
        tick();
        detect_add = 1'b0;
        if (hdr[1:0] != 2'b11) model_hdr = hdr;
        checks++;
        if (parity_done !== 1'b0) begin
            errors++;
            $display("FAIL detect_parity_done: got %b want 0", parity_done);
        end
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL detect_err_clear: got %b want 0", err);
        end

        lfd_state = 1'b1;
        data_in   = 8'($urandom);
        tick();
        lfd_state = 1'b0;
        checks++;
        if (dout !== model_hdr) begin
            errors++;
            $display("FAIL dout_header: got %h want %h", dout, model_hdr);
        end
        last    = model_hdr;
        exp_par = model_hdr;

        for (int i = 0; i <= pl_q.size(); i++) begin
            is_par    = (i == pl_q.size());
            b         = is_par ? par : pl_q[i];
            full      = rnd_full ? ($urandom_range(0, 3) == 0) : (i == full_idx);
            ld_state  = 1'b1;
            pkt_valid = !is_par;
            data_in   = b;
            fifo_full = full;
            tick();
            ld_state = 1'b0;
            if (!is_par) exp_par ^= b;
            if (!full) begin
                checks++;
                if (dout !== b) begin
                    errors++;
                    $display("FAIL dout_load[%0d]: got %h want %h", i, dout, b);
                end
            end else begin
                checks++;
                if (dout !== last) begin
                    errors++;
                    $display("FAIL dout_hold_on_full[%0d]: got %h want %h", i, dout, last);
                end
                n          = rnd_full ? $urandom_range(1, 3) : 1;
                full_state = 1'b1;
                data_in    = 8'($urandom);
                repeat (n) tick();
                full_state = 1'b0;
                checks++;
                if (dout !== last) begin
                    errors++;
                    $display("FAIL dout_hold_full_state[%0d]: got %h want %h", i, dout, last);
                end
                if (is_par) begin
                    checks++;
                    if (parity_done !== 1'b0) begin
                        errors++;
                        $display("FAIL parity_done_early: got %b want 0", parity_done);
                    end
                    checks++;
                    if (low_pkt_valid !== 1'b1) begin
                        errors++;
                        $display("FAIL low_pkt_valid_held: got %b want 1", low_pkt_valid);
                    end
                end
                laf_state = 1'b1;
                fifo_full = 1'b0;
                tick();
                laf_state = 1'b0;
                checks++;
                if (dout !== b) begin
                    errors++;
                    $display("FAIL dout_replay[%0d]: got %h want %h", i, dout, b);
                end
            end
            last = b;
        end
        fifo_full = 1'b0;
        checks++;
        if (parity_done !== 1'b1) begin
            errors++;
            $display("FAIL parity_done_set: got %b want 1", parity_done);
        end
        checks++;
        if (low_pkt_valid !== 1'b1) begin
            errors++;
            $display("FAIL low_pkt_valid_set: got %b want 1", low_pkt_valid);
        end

        rst_int_reg = 1'b1;
        tick();
        rst_int_reg = 1'b0;
        checks++;
        if (err !== (exp_par != par)) begin
            errors++;
            $display("FAIL err_value: got %b want %b (calc %h rx %h)", err, exp_par != par,
                     exp_par, par);
        end
        checks++;
        if (low_pkt_valid !== 1'b0) begin
            errors++;
            $display("FAIL low_pkt_valid_clear: got %b want 0", low_pkt_valid);
        end
        tick();
        checks++;
        if (err !== (exp_par != par)) begin
            errors++;
            $display("FAIL err_stable: got %b want %b", err, exp_par != par);
        end
    endtask

    task automatic test_reset();
        clear_strobes();
        pkt_valid = 1'b0;
        data_in   = 8'h00;
        resetn    = 1'b0;
        model_hdr = 8'h00;
        #12;
        checks++;
        if ({dout, parity_done, low_pkt_valid, err} !== 11'h0) begin
            errors++;
            $display("FAIL reset_state: got dout=%h pd=%b lpv=%b err=%b want all 0", dout,
                     parity_done, low_pkt_valid, err);
        end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_good_packet();
        pl_q = '{8'hA1, 8'hB2, 8'hC3};
        send_packet(8'h0D, 8'hDD, -1, 1'b0);
    endtask

    task automatic test_bad_parity();
        pl_q = '{8'hA1, 8'hB2, 8'hC3};
        send_packet(8'h0D, 8'hDE, -1, 1'b0);
    endtask

    task automatic test_full_payload();
        pl_q = '{8'hA1, 8'hB2, 8'hC3};
        send_packet(8'h0D, 8'hDD, 1, 1'b0);
    endtask

    task automatic test_full_parity();
        pl_q = '{8'hA1, 8'hB2, 8'hC3};
        send_packet(8'h0D, 8'hDD, 3, 1'b0);
    endtask

    task automatic test_invalid_header();
        // Header 03 is rejected, so the previous 0D header and parity apply.
        pl_q = '{8'hA1, 8'hB2, 8'hC3};
        send_packet(8'h03, 8'hDD, -1, 1'b0);
    endtask

    task automatic test_reset_mid_payload();
        clear_strobes();
        detect_add = 1'b1;
        pkt_valid  = 1'b1;
        data_in    = 8'h0D;
        tick();
        detect_add = 1'b0;
        lfd_state  = 1'b1;
        tick();
        lfd_state = 1'b0;
        ld_state  = 1'b1;
        data_in   = 8'hA1;
        tick();
        ld_state = 1'b0;
        checks++;
        if (dout !== 8'hA1) begin
            errors++;
            $display("FAIL pre_reset_dout: got %h want a1", dout);
        end
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if ({dout, parity_done, low_pkt_valid, err} !== 11'h0) begin
            errors++;
            $display("FAIL async_reset: got dout=%h pd=%b lpv=%b err=%b want all 0", dout,
                     parity_done, low_pkt_valid, err);
        end
        #2;
        resetn    = 1'b1;
        model_hdr = 8'h00;
        tick();
        // Header register was cleared: invalid header replays 00, parity is just A1.
        pl_q = '{8'hA1};
        send_packet(8'h0B, 8'hA1, -1, 1'b0);
    endtask

    task automatic test_random();
        logic [7:0] hdr;
        logic [7:0] eff_hdr;
        logic [7:0] good;
        logic [7:0] par;
        int         len;
        for (int p = 0; p < 25; p++) begin
            hdr     = 8'($urandom);
            eff_hdr = (hdr[1:0] != 2'b11) ? hdr : model_hdr;
            len     = $urandom_range(1, 6);
            pl_q    = {};
            good    = eff_hdr;
            for (int k = 0; k < len; k++) begin
                pl_q.push_back(8'($urandom));
                good ^= pl_q[k];
            end
            par = ($urandom_range(0, 1) == 0) ? good : (good ^ 8'($urandom_range(1, 255)));
            send_packet(hdr, par, -1, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_good_packet();
        test_bad_parity();
        test_full_payload();
        test_full_parity();
        test_invalid_header();
        test_reset_mid_payload();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
